// File: rtl/tft_arb_pkg.sv
// tft_arb_pkg: shared definitions for the TFT SPI bus arbiter.
// Holds the arbiter state encoding, the default requester count, the
// requester index map and the width of the per-grant byte counter.
package tft_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int N_DEFAULT  = 3;

  // Requester slots on the shared transmitter.
  localparam int REQ_INIT   = 0;
  localparam int REQ_SCENE  = 1;
  localparam int REQ_PLAYER = 2;

  localparam int BYTE_CNT_W = 16;

endpackage

// File: rtl/tft_arb_rr_pick.sv
// tft_arb_rr_pick: combinational masked round-robin selector.
// Picks the first requester i with req[i] & ~mask[i], scanning from ptr
// upward and wrapping modulo N.
// Ports:
//   req   in  N          request levels
//   mask  in  N          requesters currently barred from selection
//   ptr   in  clog2(N)   scan start index
//   valid out 1          at least one eligible requester
//   idx   out clog2(N)   selected requester index (0 when !valid)
module tft_arb_rr_pick
  import tft_arb_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [N-1:0] cand;

  assign cand = req & ~mask;

  // Scan from the far end back toward ptr so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    valid = |cand;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter: round-robin arbiter/sequencer sharing one tft_spi byte
// transmitter between tft_init (0), scene_exhibitor (1) and player (2).
// A requester keeps the bus for a whole burst (req held high). Strobes from
// the owner pass straight through to the shifter when it is idle; strobes
// while the shifter is busy are dropped and flagged. The bus is handed over
// only after the shifter has gone idle (DRAIN state).
// Optional feature macro: TFT_ARB_WATCHDOG_EN enables the idle-grant
// watchdog (WDOG_CYCLES) that revokes a silent owner and masks it until it
// drops its request.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   req/req_data/req_dc/req_transmit   per-requester request, byte, dc, strobe
//   gnt              registered one-hot grant
//   req_busy         per-requester busy = spi_busy | ~gnt[i]
//   spi_busy         busy from tft_spi
//   spi_data/spi_dc/spi_transmit       muxed byte/dc/strobe to tft_spi
//   owner            current or last grantee
//   byte_count       bytes forwarded in the current grant (saturating)
//   proto_err        sticky: owner strobed while spi_busy was high
//   timeout          sticky: watchdog revoked a grant
// Handshake: a byte is accepted by tft_spi exactly in a cycle where
// spi_transmit is high; spi_transmit is only raised when spi_busy is low.
module tft_bus_arbiter
  import tft_arb_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [8*N-1:0]        req_data,
  input  logic [N-1:0]          req_dc,
  input  logic [N-1:0]          req_transmit,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          req_busy,
  input  logic                  spi_busy,
  output logic [7:0]            spi_data,
  output logic                  spi_dc,
  output logic                  spi_transmit,
  output logic [$clog2(N)-1:0]  owner,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  proto_err,
  output logic                  timeout
);

  localparam int IW = $clog2(N);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [N-1:0]  mask;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          in_grant;
  logic          own_strobe;
  logic          fwd;
  logic          revoke;
  logic [IW-1:0] owner_inc;

  tft_arb_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Strobe path: one mux level off the registered owner, gated by state.
  // rst is folded in so the SPI side is quiet for the whole reset window.
  assign in_grant     = rst && (state == ST_GRANT);
  assign own_strobe   = in_grant && req_transmit[owner];
  assign fwd          = own_strobe && !spi_busy;
  assign spi_transmit = fwd;
  assign spi_data     = in_grant ? req_data[int'(owner) * 8 +: 8] : 8'h00;
  assign spi_dc       = in_grant && req_dc[owner];
  assign req_busy     = {N{spi_busy}} | ~gnt;
  assign owner_inc    = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

`ifdef TFT_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

  logic [15:0] wdog_cnt;

  // Revoke on the edge where the idle count would reach the limit, so a
  // silent owner holds gnt for exactly WDOG_CYCLES cycles.
  assign revoke = in_grant && !fwd && !spi_busy &&
                  (wdog_cnt + 16'd1 == WDOG_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
      mask     <= '0;
    end else begin
      // A masked requester is released once it lets go of req.
      mask <= (mask & req) | ({{(N-1){1'b0}}, revoke} << owner);
      if (revoke) begin
        timeout <= 1'b1;
      end
      // Clearing throughout IDLE covers the clear on entry to GRANT.
      if (state == ST_IDLE) begin
        wdog_cnt <= '0;
      end else if (in_grant) begin
        if (fwd) begin
          wdog_cnt <= '0;
        end else if (!spi_busy) begin
          wdog_cnt <= wdog_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign revoke  = 1'b0;
  assign mask    = '0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      ptr        <= '0;
      byte_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (own_strobe && spi_busy) begin
        proto_err <= 1'b1;
      end
      if (fwd && (byte_count != '1)) begin
        byte_count <= byte_count + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner      <= pick_idx;
            gnt        <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            byte_count <= '0;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A strobe in this same cycle is still forwarded combinationally.
          if (!req[owner] || revoke) begin
            gnt   <= '0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!spi_busy) begin
            ptr   <= owner_inc;
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// tb_tft_bus_arbiter: self-checking bench for tft_bus_arbiter (N=3).
// Expected SPI bytes are queued when a strobe is driven that must reach the
// shifter, and popped by a monitor whenever spi_transmit is seen high.
module tb_tft_bus_arbiter;
  import tft_arb_pkg::*;

  localparam int N = 3;
`ifdef TFT_ARB_WATCHDOG_EN
  localparam int WDOG = 8;
`else
  localparam int WDOG = 65535;
`endif

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          req;
  logic [8*N-1:0]        req_data;
  logic [N-1:0]          req_dc;
  logic [N-1:0]          req_transmit;
  logic [N-1:0]          gnt;
  logic [N-1:0]          req_busy;
  logic                  spi_busy;
  logic [7:0]            spi_data;
  logic                  spi_dc;
  logic                  spi_transmit;
  logic [$clog2(N)-1:0]  owner;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  proto_err;
  logic                  timeout;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  tft_bus_arbiter #(.N(N), .WDOG_CYCLES(WDOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_dc       (req_dc),
    .req_transmit (req_transmit),
    .gnt          (gnt),
    .req_busy     (req_busy),
    .spi_busy     (spi_busy),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_transmit),
    .owner        (owner),
    .byte_count   (byte_count),
    .proto_err    (proto_err),
    .timeout      (timeout)
  );

  // Clock / run bound
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "run bound exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every byte reaching tft_spi must match the queue head.
  always @(negedge clk) begin
    if (rst && spi_transmit) begin
      if (exp_q.size() == 0) begin
        check("spi_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("spi_byte", {23'd0, spi_dc, spi_data}, {23'd0, mon_exp});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    req          = '0;
    req_transmit = '0;
    spi_busy     = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // One-cycle strobe from requester idx; exp_tx says whether it must reach
  // the shifter this cycle.
  task automatic send_byte(input int idx, input logic [7:0] d, input logic dc,
                           input logic exp_tx);
    req_data[8*idx +: 8] = d;
    req_dc[idx]          = dc;
    req_transmit[idx]    = 1'b1;
    if (exp_tx) exp_q.push_back({dc, d});
    @(negedge clk);
    check("tx_strobe", {31'd0, spi_transmit}, {31'd0, exp_tx});
    @(posedge clk);
    #1;
    req_transmit[idx] = 1'b0;
  endtask

  // Bounded wait for any grant; cycles = ticks spent waiting.
  task automatic wait_gnt(output int cycles);
    cycles = 0;
    while (gnt == '0 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  int cyc;
  int exp_own;

  initial begin
    // Reset with every requester asking
    rst = 1'b0; req = '1; req_data = '0; req_dc = '0; req_transmit = '0;
    spi_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_tx", spi_transmit, 0);
    check("rst_owner", owner, 0);
    check("rst_bc", byte_count, 0);
    check("rst_perr", proto_err, 0);
    check("rst_tmo", timeout, 0);
    tick();
    rst = 1'b1;
    req = '0;
    tick();

    // Single burst from tft_init
    req = 3'b001;
    @(negedge clk);
    check("t1_gnt_pre", gnt, 0);
    tick();
    check("t1_gnt_lat", gnt, 3'b001);
    for (int k = 0; k < 4; k++) begin
      send_byte(REQ_INIT, 8'(8'hA0 + k), k[0], 1'b1);
      tick();
    end
    check("t1_bytes", byte_count, 4);
    req[REQ_INIT] = 1'b0;
    tick();
    check("t1_release", gnt, 0);
    tick();
    tick();
    check("t1_bc_hold", byte_count, 4);

    // Round robin with all three requesting
    do_reset();
    req = 3'b111;
    exp_own = 0;
    for (int b = 0; b < 4; b++) begin
      wait_gnt(cyc);
      check("rr_gnt", gnt, 32'(1 << exp_own));
      check("rr_owner", owner, exp_own);
      if (b > 0) check("rr_handover", cyc + 1, 3);
      send_byte(exp_own, 8'(8'h10 * b + 1), 1'b0, 1'b1);
      send_byte(exp_own, 8'(8'h10 * b + 2), 1'b1, 1'b1);
      check("rr_bytes", byte_count, 2);
      req[exp_own] = 1'b0;
      tick();
      req[exp_own] = 1'b1;
      exp_own = (exp_own + 1) % N;
    end

    // Busy collision and non-owner strobes
    do_reset();
    req = 3'b010;
    wait_gnt(cyc);
    check("col_gnt", gnt, 3'b010);
    check("col_req_busy", req_busy, 3'b101);
    send_byte(REQ_SCENE, 8'h5A, 1'b1, 1'b1);
    spi_busy = 1'b1;
    @(negedge clk);
    check("col_req_busy_b", req_busy, 3'b111);
    tick();
    send_byte(REQ_INIT, 8'h11, 1'b0, 1'b0);
    check("col_nonowner_perr", proto_err, 0);
    send_byte(REQ_SCENE, 8'h22, 1'b0, 1'b0);
    check("col_perr", proto_err, 1);
    check("col_bc", byte_count, 1);
    spi_busy = 1'b0;
    repeat (3) tick();
    check("col_perr_sticky", proto_err, 1);
    send_byte(REQ_SCENE, 8'h33, 1'b0, 1'b1);
    check("col_bc2", byte_count, 2);

    // Drain: owner releases while the shifter stays busy
    spi_busy = 1'b1;
    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("dr_hold", gnt, 0);
    end
    spi_busy = 1'b0;
    tick();
    check("dr_after1", gnt, 0);
    tick();
    check("dr_after2", gnt, 3'b100);
    check("dr_owner", owner, REQ_PLAYER);
    req = '0;
    tick();

`ifdef TFT_ARB_WATCHDOG_EN
    // Watchdog: silent owner is revoked and masked
    do_reset();
    req = 3'b010;
    wait_gnt(cyc);
    check("wd_gnt", gnt, 3'b010);
    cyc = 0;
    while (gnt == 3'b010 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("wd_hold_cycles", cyc, WDOG);
    check("wd_timeout", timeout, 1);
    repeat (6) tick();
    check("wd_masked", gnt, 0);
    req = 3'b110;
    wait_gnt(cyc);
    check("wd_next", gnt, 3'b100);
`else
    check("no_wd_timeout", timeout, 0);
`endif

    repeat (2) tick();
    check("spi_leftover", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tft_bus_arbiter.md
# tft_bus_arbiter

Round-robin arbiter and sequencer that shares the single `tft_spi` byte transmitter between the display requesters: `tft_init`, `scene_exhibitor` and `player`. It replaces the ad-hoc enable-based priority mux in the top level. A requester holds the bus for a whole drawing burst. The arbiter forwards only well-formed transmit strobes, and hands the bus over only once the SPI shifter is idle.

## Interface
Parameters:
- `N`, default 3: number of requesters. Index 0 is `tft_init`, 1 is `scene_exhibitor`, 2 is `player`.
- `WDOG_CYCLES`, default 65535: idle-grant timeout in clk cycles. Used only with `TFT_ARB_WATCHDOG_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `req` in N: bus request per requester, level; held for the whole burst.
- `req_data` in 8N: byte per requester; slice i is `[8i+7:8i]`.
- `req_dc` in N: data/command flag per requester.
- `req_transmit` in N: one-cycle byte strobe per requester.
- `gnt` out N: one-hot grant, registered.
- `req_busy` out N: per-requester busy, equal to `spi_busy | ~gnt[i]`, combinational.
- `spi_busy` in 1: busy from `tft_spi`.
- `spi_data` out 8: byte to `tft_spi`.
- `spi_dc` out 1: dc to `tft_spi`.
- `spi_transmit` out 1: strobe to `tft_spi`.
- `owner` out `$clog2(N)`: index of the current or last grantee.
- `byte_count` out 16: number of bytes forwarded in the current grant.
- `proto_err` out 1: sticky flag; a transmit strobe arrived while `spi_busy` was high.
- `timeout` out 1: sticky flag; the watchdog revoked a grant.

## Operation
States and transitions:
- IDLE
  - If `req & ~mask` is nonzero, select the first set bit at or after `ptr`, wrapping modulo N.
  - Load `owner`, set `gnt[owner]`, clear `byte_count`, go to GRANT.
- GRANT
  - `spi_data`, `spi_dc` and `spi_transmit` are driven from slice `owner`.
  - `spi_transmit` is `req_transmit[owner] & ~spi_busy`.
  - Each forwarded strobe increments `byte_count`, saturating at 16'hFFFF.
  - A strobe arriving while `spi_busy` is high is dropped, and `proto_err` is set.
  - When `req[owner]` falls, clear `gnt` and go to DRAIN. A strobe in that same cycle is still forwarded.
- DRAIN
  - All SPI outputs are 0.
  - Wait until `spi_busy` is 0, staying at least 1 cycle.
  - Then set `ptr` to `owner+1` (wrapping at N) and go to IDLE.

Other rules:
- Strobes from non-owners are ignored silently; they do not set `proto_err`.
- In IDLE and DRAIN, `spi_data` is 0, `spi_dc` is 0 and `spi_transmit` is 0.
- `byte_count` holds its value after release, until the next grant.

Reset values (while `rst` is 0):
- State IDLE.
- `gnt` 0, `owner` 0, `ptr` 0, `byte_count` 0.
- `proto_err` 0, `timeout` 0, `mask` 0.
- All SPI outputs 0.
- Reset mid-burst drops the grant immediately. Any byte already inside `tft_spi` is not tracked.

## Timing
- Grant latency: `req` rising in cycle t with the bus in IDLE gives `gnt` high in cycle t+1.
- Strobe path is zero-latency. It is combinational from registered `owner`/`gnt`, with one mux level.
- Handover, from `req` falling to the next `gnt`:
  - 3 cycles minimum: GRANT→DRAIN, DRAIN→IDLE, IDLE→GRANT.
  - More while `spi_busy` is held high.
- Simultaneous requests are resolved by the round-robin pointer only. No requester starves; the worst-case wait is N−1 bursts.

## Configuration
`TFT_ARB_WATCHDOG_EN` defined:
- A 16-bit counter clears on every forwarded strobe and on entry to GRANT.
- It increments in GRANT while `spi_busy` is 0.
- When the counter reaches `WDOG_CYCLES`:
  - Revoke the grant and go to DRAIN.
  - Set `timeout`.
  - Set `mask[owner]`.
- `mask[i]` clears when `req[i]` is low. A revoked requester must therefore drop `req` before it can be granted again.

`TFT_ARB_WATCHDOG_EN` undefined:
- No counter.
- `mask` is constant 0.
- `timeout` is tied to 0.
- `WDOG_CYCLES` is ignored.

## Structure
Shared package `tft_arb_pkg` holds:
- The state enum (IDLE, GRANT, DRAIN).
- The default N.
- Requester index constants: REQ_INIT=0, REQ_SCENE=1, REQ_PLAYER=2.
- `BYTE_CNT_W`=16.

One sub-module, `tft_arb_rr_pick`: a combinational masked round-robin selector.
- Inputs: `req`, `mask`, `ptr`.
- Outputs: `valid`, `idx`.

The FSM, counters and muxes live in the top of the block.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all `req`=1 → `gnt`=0, `spi_transmit`=0, `owner`=0, flags 0.
- Single burst: `req`=3'b001, 4 strobes spaced so they land while `spi_busy` is 0, then drop `req` → `gnt`=001 one cycle after `req`, 4 `spi_transmit` pulses carrying the matching data/dc, `byte_count`=4, `gnt`=0 the cycle after `req` drops.
- Round-robin: `req`=3'b111 held → grant order 0,1,2,0. Each holder drops `req` after 2 bytes; each handover takes ≥3 cycles.
- Busy collision: strobe from the owner while `spi_busy`=1 → no `spi_transmit`, `proto_err`=1 and stays set, `byte_count` unchanged.
- Drain: drop `req[owner]` while `spi_busy` stays high for 10 cycles → no new `gnt` until 2 cycles after `spi_busy` falls.
- Watchdog (macro on, `WDOG_CYCLES`=8): granted requester 1 idles → grant revoked after 8 idle cycles, `timeout`=1. Requester 1 is not regranted while its `req` stays high; requester 2 is granted.
